// File: rtl/conway_pkg.sv
// Shared definitions for the Conway frame scan-out path: block geometry,
// bank mapping, FSM encoding and the pixel word carried through the output FIFO.
package conway_pkg;

    localparam int PIXELS_PER_BLOCK = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic data;
        logic sof;
        logic eol;
    } pixel_t;

    // Cells are interleaved over a 3x3 bank array by their position inside the block.
    function automatic logic [3:0] bank_index(input logic [1:0] px, input logic [1:0] py);
        return 4'(px) + 4'(py) * 4'(PIXELS_PER_BLOCK);
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO between the memory return path and the pixel stream; the head
// entry stays put until it is popped, so the stream holds steady under backpressure.
module skid_fifo2 #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] store [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != 2'd0);
    assign do_pop    = pop & not_empty;
    assign do_push   = push & ((count != 2'd2) | do_pop);
    assign head      = store[rd_ptr];

    // NOTE: the two storage words are reset too, so the stream outputs read 0 straight out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            store[0] <= '0;
            store[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wrap_counter.sv
// Modulo counter: counts 0..MAX on inc, wraps to 0, and flags the terminal value
// so counters can be chained into a raster position.
module wrap_counter #(
    parameter int WIDTH = 2,
    parameter int MAX   = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    assign last = (count == WIDTH'(MAX));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// Scans one frame of a banked cell memory in raster order and streams it out
// as a valid/ready pixel stream with start-of-frame and end-of-line markers.
module frame_scanout #(
    parameter int ADDR_WIDTH       = 2,
    parameter int WIDTH_BLOCKS     = 2,
    parameter int HEIGHT_BLOCKS    = 2,
    parameter int PIXELS_PER_BLOCK = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  frame_buffer_select,
    output logic [8:0]            mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_rd_buffer,
    input  logic [8:0]            mem_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  busy,
    output logic                  frame_done
);

    import conway_pkg::*;

    localparam int BXW = (WIDTH_BLOCKS  > 1) ? $clog2(WIDTH_BLOCKS)  : 1;
    localparam int BYW = (HEIGHT_BLOCKS > 1) ? $clog2(HEIGHT_BLOCKS) : 1;

    scan_state_t    state;
    scan_state_t    state_next;

    logic [1:0]     px;
    logic [1:0]     py;
    logic [BXW-1:0] bx;
    logic [BYW-1:0] by;
    logic           px_last;
    logic           py_last;
    logic           bx_last;
    logic           by_last;
    logic           x_last;
    logic           frame_last;
    logic [3:0]     bank;

    logic           clear_cnt;
    logic           latch_buffer;
    logic           issue;
    logic           credit_ok;

    logic           rd_pending;
    logic [3:0]     bank_q;
    logic           sof_q;
    logic           eol_q;

    pixel_t         push_pixel;
    pixel_t         head_pixel;
    logic           fifo_not_empty;
    logic [1:0]     fifo_count;

    // Raster position is kept as pixel-in-block and block counters, so no divide is needed.
    wrap_counter #(.WIDTH(2), .MAX(PIXELS_PER_BLOCK - 1)) u_px (
        .clk(clk), .resetn(resetn), .clear(clear_cnt), .inc(issue),
        .count(px), .last(px_last)
    );
    wrap_counter #(.WIDTH(BXW), .MAX(WIDTH_BLOCKS - 1)) u_bx (
        .clk(clk), .resetn(resetn), .clear(clear_cnt), .inc(issue & px_last),
        .count(bx), .last(bx_last)
    );
    wrap_counter #(.WIDTH(2), .MAX(PIXELS_PER_BLOCK - 1)) u_py (
        .clk(clk), .resetn(resetn), .clear(clear_cnt), .inc(issue & x_last),
        .count(py), .last(py_last)
    );
    wrap_counter #(.WIDTH(BYW), .MAX(HEIGHT_BLOCKS - 1)) u_by (
        .clk(clk), .resetn(resetn), .clear(clear_cnt), .inc(issue & x_last & py_last),
        .count(by), .last(by_last)
    );

    assign x_last      = px_last & bx_last;
    assign frame_last  = x_last & py_last & by_last;
    assign bank        = bank_index(px, py);
    assign mem_rd_addr = ADDR_WIDTH'(bx) + ADDR_WIDTH'(by) * ADDR_WIDTH'(WIDTH_BLOCKS);
    assign mem_rd_en   = issue ? (9'd1 << bank) : 9'd0;

    // A read is only launched when its data is guaranteed a FIFO slot on return.
    assign credit_ok = (({1'b0, rd_pending} + fifo_count) < 2'd2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        clear_cnt    = 1'b0;
        latch_buffer = 1'b0;
        issue        = 1'b0;
        frame_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_SCAN;
                    clear_cnt    = 1'b1;
                    latch_buffer = 1'b1;
                end
            end
            ST_SCAN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (frame_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_pending && !fifo_not_empty) begin
                    state_next = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_rd_buffer <= 1'b0;
        end else if (latch_buffer) begin
            mem_rd_buffer <= ~frame_buffer_select;
        end
    end

    // Flags travel beside the read so they meet the returned bit one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pending <= 1'b0;
            bank_q     <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                bank_q <= bank;
                sof_q  <= (px == '0) && (bx == '0) && (py == '0) && (by == '0);
                eol_q  <= x_last;
            end
        end
    end

    assign push_pixel = '{data: mem_rd_data[bank_q], sof: sof_q, eol: eol_q};

    skid_fifo2 #(.WIDTH($bits(pixel_t))) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rd_pending),
        .push_data (push_pixel),
        .pop       (m_ready),
        .head      (head_pixel),
        .not_empty (fifo_not_empty),
        .count     (fifo_count)
    );

    assign m_valid = fifo_not_empty;
    assign m_data  = head_pixel.data;
    assign m_sof   = head_pixel.sof;
    assign m_eol   = head_pixel.eol;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout: reference memory, raster scoreboard on the
// read and pixel interfaces, backpressure, buffer latching and mid-frame reset.
module tb_frame_scanout;

    localparam int W    = 6;
    localparam int H    = 6;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       frame_buffer_select = 1'b0;
    logic       m_ready = 1'b0;
    logic [8:0] mem_rd_en;
    logic [1:0] mem_rd_addr;
    logic       mem_rd_buffer;
    logic [8:0] mem_rd_data = 9'd0;
    logic       m_valid, m_data, m_sof, m_eol, busy, frame_done;

    int   tests = 0;
    int   fails = 0;
    bit   mem_model [2][9][4];
    int   iss_idx, pop_idx, done_cnt, cyc, last_pop_cyc, done_cyc;
    int   mx, my;
    logic exp_buf;
    bit   ready_rand = 1'b0;
    bit   stall_q;
    logic [2:0] stall_val;
    logic [8:0] en16, en35;
    logic [1:0] addr16, addr35;

    always #5 clk = ~clk;

    frame_scanout dut (
        .clk                 (clk),
        .resetn              (resetn),
        .start               (start),
        .frame_buffer_select (frame_buffer_select),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_buffer       (mem_rd_buffer),
        .mem_rd_data         (mem_rd_data),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .m_data              (m_data),
        .m_sof               (m_sof),
        .m_eol               (m_eol),
        .busy                (busy),
        .frame_done          (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_pixel(input logic b, input int x, input int y);
        return mem_model[b][(x % 3) + 3 * (y % 3)][(x / 3) + (y / 3) * 2];
    endfunction

    function automatic logic [8:0] mem_word(input logic b, input logic [1:0] a);
        logic [8:0] w;
        for (int k = 0; k < 9; k++) w[k] = mem_model[b][k][a];
        return w;
    endfunction

    // Memory returns the addressed word one cycle after a read; garbage otherwise.
    always @(posedge clk) begin
        mem_rd_data <= (mem_rd_en != 9'd0) ? mem_word(mem_rd_buffer, mem_rd_addr) : 9'($urandom);
    end

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) m_ready = ($urandom_range(0, 99) < 30);
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (stall_q) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_bits", 32'({m_data, m_sof, m_eol}), 32'(stall_val));
            end
            stall_q = 1'b0;
            if (mem_rd_en != 9'd0) begin
                mx = iss_idx % W;
                my = (iss_idx / W) % H;
                check("rd_credit", 32'((iss_idx - pop_idx) < 2), 32'd1);
                check("rd_en", 32'(mem_rd_en), 32'd1 << ((mx % 3) + 3 * (my % 3)));
                check("rd_addr", 32'(mem_rd_addr), 32'((mx / 3) + (my / 3) * 2));
                check("rd_buffer", 32'(mem_rd_buffer), 32'(exp_buf));
                if (iss_idx == 16) begin en16 = mem_rd_en; addr16 = mem_rd_addr; end
                if (iss_idx == 35) begin en35 = mem_rd_en; addr35 = mem_rd_addr; end
                iss_idx++;
            end
            if (m_valid && m_ready) begin
                mx = pop_idx % W;
                my = (pop_idx / W) % H;
                check("pix_data", 32'(m_data), 32'(exp_pixel(exp_buf, mx, my)));
                check("pix_sof", 32'(m_sof), 32'(pop_idx == 0));
                check("pix_eol", 32'(m_eol), 32'(mx == W - 1));
                pop_idx++;
                last_pop_cyc = cyc;
            end else if (m_valid) begin
                stall_q   = 1'b1;
                stall_val = {m_data, m_sof, m_eol};
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic reset_sb();
        iss_idx      = 0;
        pop_idx      = 0;
        done_cnt     = 0;
        stall_q      = 1'b0;
        last_pop_cyc = 0;
        done_cyc     = -100;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},     32'(mem_rd_en),     32'd0);
        check({tag, "_rd_addr"},   32'(mem_rd_addr),   32'd0);
        check({tag, "_rd_buffer"}, 32'(mem_rd_buffer), 32'd0);
        check({tag, "_valid"},     32'(m_valid),       32'd0);
        check({tag, "_data"},      32'(m_data),        32'd0);
        check({tag, "_sof"},       32'(m_sof),         32'd0);
        check({tag, "_eol"},       32'(m_eol),         32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_done"},      32'(frame_done),    32'd0);
    endtask

    task automatic wait_frame_end(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_pixels"}, 32'(pop_idx), 32'(NPIX));
        check({tag, "_reads"}, 32'(iss_idx), 32'(NPIX));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_latency"}, 32'(done_cyc - last_pop_cyc), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_reads(input int target, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (iss_idx >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("reads_progress", 32'(ok), 32'd1);
    endtask

    initial begin
        for (int b = 0; b < 9; b++) begin
            for (int a = 0; a < 4; a++) begin
                mem_model[0][b][a] = (((b * 5) + (a * 3) + (b * a)) % 3) == 1;
                mem_model[1][b][a] = !mem_model[0][b][a];
            end
        end
        reset_sb();
        exp_buf = 1'b0;

        #3;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Frame A: full throughput, engine writing buffer 1 so buffer 0 is scanned.
        frame_buffer_select = 1'b1;
        exp_buf = 1'b0;
        m_ready = 1'b1;
        reset_sb();
        pulse_start();
        check("a_busy", 32'(busy), 32'd1);
        wait_frame_end("a", 500);
        check("a_en_4_2",   32'(en16),   32'h080);
        check("a_addr_4_2", 32'(addr16), 32'd1);
        check("a_en_5_5",   32'(en35),   32'h100);
        check("a_addr_5_5", 32'(addr35), 32'd3);

        // Frame B: 30% ready, select toggled and start re-pulsed mid-scan.
        frame_buffer_select = 1'b0;
        exp_buf = 1'b1;
        reset_sb();
        ready_rand = 1'b1;
        pulse_start();
        wait_reads(10, 400);
        check("b_busy_mid", 32'(busy), 32'd1);
        frame_buffer_select = 1'b1;
        pulse_start();
        frame_buffer_select = 1'b0;
        @(negedge clk);
        frame_buffer_select = 1'b1;
        wait_frame_end("b", 3000);
        check("b_buffer_held", 32'(mem_rd_buffer), 32'd1);
        ready_rand = 1'b0;
        @(posedge clk); #1 m_ready = 1'b1;

        // Frame C: reset asserted at pixel 17, then a clean frame.
        frame_buffer_select = 1'b1;
        exp_buf = 1'b0;
        reset_sb();
        pulse_start();
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk); #1;
                if (pop_idx >= 17) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("c_reach_17", 32'(ok), 32'd1);
        end
        #1 resetn = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        reset_sb();
        pulse_start();
        wait_frame_end("c", 500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_scanout.md
FRAME_SCANOUT -- requirements
Module: frame_scanout

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, meaning per-bank address width.
REQ-002 Parameter WIDTH_BLOCKS, default 2, meaning blocks per row.
REQ-003 Parameter HEIGHT_BLOCKS, default 2, meaning block rows per frame.
REQ-004 Parameter PIXELS_PER_BLOCK, default 3, meaning block edge in pixels (fixed at 3).
REQ-005 Port clk input 1 sets the single clock; all logic SHALL be rising-edge.
REQ-006 Port resetn input 1 SHALL be the asynchronous, active-low reset.
REQ-007 Port start input 1 requests one frame scan.
REQ-008 Port frame_buffer_select input 1 identifies the buffer the generation engine is writing.
REQ-009 Port mem_rd_en output 9 is a one-hot bank read enable (bank = x%3 + 3*(y%3)).
REQ-010 Port mem_rd_addr output ADDR_WIDTH is shared by all banks.
REQ-011 Port mem_rd_buffer output 1 selects the buffer being read.
REQ-012 Port mem_rd_data input 9 carries one cell bit per bank, valid exactly 1 cycle after mem_rd_en.
REQ-013 Port m_valid output 1, m_ready input 1, m_data output 1, m_sof output 1, m_eol output 1 form the pixel stream.
REQ-014 Port busy output 1 is high outside IDLE; frame_done output 1 is a one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, SCAN, DRAIN.
REQ-016 In IDLE, start=1 SHALL latch mem_rd_buffer <= ~frame_buffer_select, clear the x/y pixel counters, and enter SCAN.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 Raster order: x counts 0..3*WIDTH_BLOCKS-1; wrap of x increments y.
REQ-019 mem_rd_addr SHALL equal x/3 + (y/3)*WIDTH_BLOCKS, formed from pixel-within-block and block counters (no divider).
REQ-020 A read SHALL issue (mem_rd_en nonzero, one-hot) only when SCAN and outstanding reads + FIFO occupancy < 2.
REQ-021 mem_rd_en SHALL be all-zero whenever no read issues.
REQ-022 The bank index, sof (x=0,y=0), and eol (x=max) flags SHALL be pipelined 1 cycle beside the read.
REQ-023 The returned bit SHALL be selected by the pipelined bank index and pushed into a 2-entry output FIFO with its flags.
REQ-024 m_valid SHALL equal FIFO non-empty; a pop occurs on m_valid & m_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-025 m_data/m_sof/m_eol SHALL be stable while m_valid=1 and m_ready=0.
REQ-026 Issuing the last pixel (x=max, y=max) SHALL move SCAN to DRAIN.
REQ-027 DRAIN SHALL go to IDLE when the FIFO is empty and no read is outstanding, pulsing frame_done that cycle.
REQ-028 mem_rd_buffer SHALL hold constant from latch until IDLE regardless of frame_buffer_select toggles.
REQ-029 Exactly 9*WIDTH_BLOCKS*HEIGHT_BLOCKS pixels SHALL be emitted per frame, with no loss or duplication under any m_ready pattern.

Reset
REQ-030 resetn low SHALL asynchronously force IDLE and clear counters, FIFO, and pipeline; outputs SHALL be mem_rd_en=0, mem_rd_addr=0, mem_rd_buffer=0, m_valid=0, m_data=0, m_sof=0, m_eol=0, busy=0, frame_done=0.
REQ-031 Reset mid-frame SHALL discard the in-flight data; the next start SHALL begin at pixel (0,0).

Structure
REQ-032 PIXELS_PER_BLOCK, the bank-index function, and the FSM state encoding SHALL live in the shared package conway_pkg.
REQ-033 The 2-entry output FIFO SHALL be a sub-module, skid_fifo2; the counters SHALL reuse the team counter module.

Verification
REQ-034 Default params, start, m_ready=1 -> 36 pixels, first with m_sof=1, m_eol on every 6th, frame_done 1 cycle after the last pixel.
REQ-035 Pixel (x=4,y=2) read -> mem_rd_en=9'b010000000 (bank 7), mem_rd_addr=1; pixel (5,5) -> bank 8, addr 3.
REQ-036 frame_buffer_select=0 at start, toggled mid-scan -> mem_rd_buffer=1 for the whole frame.
REQ-037 m_ready random 30% duty -> all 36 bits match the memory model in order, with no FIFO overflow and mem_rd_en=0 when credit=0.
REQ-038 resetn low at pixel 17 -> outputs at reset values immediately; new start -> m_sof on the first pixel, 36 pixels total.
REQ-039 start pulsed during SCAN -> ignored; exactly one frame_done.
